// File: rtl/pooling_ctrl.sv
// pooling_ctrl: 2x2/stride-2 max-pool sequencer driving the buffer reads, comparator clear and pooled writes.
// Ports: clk, rst (async, active-high); start, fmap_width, fmap_height, rd_base, wr_base in;
//        rd_en/rd_addr to the input buffer; poolwrite to the comparator; wr_en/wr_addr to the output buffer;
//        busy, done status. Defining POOL_PERF_EN adds perf_cycles, the busy-cycle count of the last pass.
module pooling_ctrl #(
  parameter int AW = 10,
  parameter int DW = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] fmap_width,
  input  logic [DW-1:0] fmap_height,
  input  logic [AW-1:0] rd_base,
  input  logic [AW-1:0] wr_base,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          poolwrite,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done
`ifdef POOL_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_w, r_ow, r_oh, r_ox, r_oy;
  logic r_wx, r_wy;
  logic [AW-1:0] r_row, r_win, r_wa;
  logic [RD_LAT-1:0] r_v, r_l;
  logic w_start, w_last_win, w_ox_last, w_oy_last, w_empty_dims;
  logic [AW-1:0] w_row_nx;
  assign w_start = (r_state == IDLE) && start;
  assign w_last_win = r_wx & r_wy;
  assign w_ox_last = (r_ox + 1'b1) == r_ow;
  assign w_oy_last = (r_oy + 1'b1) == r_oh;
  assign w_empty_dims = ((fmap_width >> 1) == '0) || ((fmap_height >> 1) == '0);
  assign w_row_nx = r_row + AW'({r_w, 1'b0});
  assign rd_en = r_state == RUN;
  assign rd_addr = rd_en ? r_win + AW'(r_wx) + (r_wy ? AW'(r_w) : '0) : '0;
  // The last delay stage lines up with the element reaching the comparator input.
  assign wr_en = r_v[RD_LAT-1] & r_l[RD_LAT-1];
  assign poolwrite = ~r_v[RD_LAT-1] | r_l[RD_LAT-1];
  assign wr_addr = r_wa;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_start ? (w_empty_dims ? DRAIN : RUN) : IDLE;
      RUN:   w_next = (w_last_win && w_ox_last && w_oy_last) ? DRAIN : RUN;
      DRAIN: w_next = (r_v == '0) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_w <= '0;
      r_ow <= '0;
      r_oh <= '0;
      r_ox <= '0;
      r_oy <= '0;
      r_wx <= 1'b0;
      r_wy <= 1'b0;
      r_row <= '0;
      r_win <= '0;
      r_wa <= '0;
      r_v <= '0;
      r_l <= '0;
    end else begin
      r_state <= w_next;
      r_v <= RD_LAT'({r_v, rd_en});
      r_l <= RD_LAT'({r_l, rd_en & w_last_win});
      if (wr_en) r_wa <= r_wa + 1'b1;
      if (w_start) begin
        r_w <= fmap_width;
        r_ow <= fmap_width >> 1;
        r_oh <= fmap_height >> 1;
        r_ox <= '0;
        r_oy <= '0;
        r_wx <= 1'b0;
        r_wy <= 1'b0;
        r_row <= rd_base;
        r_win <= rd_base;
        r_wa <= wr_base;
      end else if (rd_en) begin
        r_wx <= ~r_wx;
        if (r_wx) r_wy <= ~r_wy;
        if (w_last_win) begin
          if (w_ox_last) begin
            r_ox <= '0;
            r_oy <= r_oy + 1'b1;
            r_row <= w_row_nx;
            r_win <= w_row_nx;
          end else begin
            r_ox <= r_ox + 1'b1;
            r_win <= r_win + AW'(2);
          end
        end
      end
    end
  end
`ifdef POOL_PERF_EN
  logic [31:0] r_perf;
  assign perf_cycles = r_perf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_perf <= '0;
    else if (w_start) r_perf <= '0;
    else if (busy) r_perf <= r_perf + 1'b1;
  end
`endif
endmodule

// File: tb/tb_pooling_ctrl.sv
// tb_pooling_ctrl: checks pooling_ctrl against a per-cycle model with a comparator and input buffer in the loop.
module tb_pooling_ctrl;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int RL = 1;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [DW-1:0] fw = '0, fh = '0;
  logic [AW-1:0] rb_i = '0, wb_i = '0;
  logic rd_en, poolwrite, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef POOL_PERF_EN
  logic [31:0] perf_cycles;
`endif
  pooling_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .fmap_width(fw), .fmap_height(fh),
    .rd_base(rb_i), .wr_base(wb_i), .rd_en(rd_en), .rd_addr(rd_addr),
    .poolwrite(poolwrite), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
`ifdef POOL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(string nm, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, $signed(act), exp);
    end
  endtask
  logic signed [7:0] mem [1024];
  logic [AW-1:0] ap [RL];
  logic signed [7:0] q, acc, cmp_out;
  assign q = mem[ap[RL-1]];
  assign cmp_out = (q > acc) ? q : acc;
  always @(posedge clk) begin
    ap[0] <= rd_addr;
    for (int i = 1; i < RL; i++) ap[i] <= ap[i-1];
  end
  always @(posedge clk or posedge rst)
    if (rst) acc <= 8'sh80;
    else acc <= poolwrite ? 8'sh80 : cmp_out;
  int mw, mrb, mwb, mow, moh, mn, mdk;
  int rd_list [256];
  int rd_got [256];
  int got [256];
  int nrd, nwr, k;
  bit active = 0;
  function automatic void build(int w, int h, int rb, int wb);
    int idx = 0;
    mw = w; mrb = rb; mwb = wb; mow = w / 2; moh = h / 2;
    for (int oy = 0; oy < moh; oy++)
      for (int ox = 0; ox < mow; ox++)
        for (int wy = 0; wy < 2; wy++)
          for (int wx = 0; wx < 2; wx++) begin
            rd_list[idx] = (rb + (2*oy + wy) * w + 2*ox + wx) % 1024;
            idx++;
          end
    mn = idx;
    mdk = (mn == 0) ? 2 : mn + RL + 2;
  endfunction
  function automatic int wmax(int j);
    int m = -128;
    for (int i = 0; i < 4; i++)
      if (int'(mem[rd_list[4*j + i]]) > m) m = int'(mem[rd_list[4*j + i]]);
    return m;
  endfunction
  always @(negedge clk) begin
    int e;
    bit v, last;
    if (active) begin
      k++;
      chk("rd_en", rd_en, (k >= 1 && k <= mn) ? 1 : 0);
      if (k >= 1 && k <= mn && rd_en) chk("rd_addr", rd_addr, rd_list[k-1]);
      if (rd_en && nrd < 256) begin rd_got[nrd] = rd_addr; nrd++; end
      e = k - 1 - RL;
      v = e >= 0 && e < mn;
      last = v && (e % 4 == 3);
      chk("wr_en", wr_en, last ? 1 : 0);
      chk("poolwrite", poolwrite, (!v || last) ? 1 : 0);
      if (last && wr_en) begin
        chk("wr_addr", wr_addr, (mwb + e / 4) % 1024);
        chk("pool_max", int'(cmp_out), wmax(e / 4));
      end
      if (wr_en && nwr < 256) begin got[nwr] = int'(cmp_out); nwr++; end
      chk("busy", busy, (k >= 1 && k <= mdk) ? 1 : 0);
      chk("done", done, (k == mdk) ? 1 : 0);
    end
  end
  task automatic idle_chk(string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_poolwrite"}, poolwrite, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic run_pass(int w, int h, int rb, int wb, int poke, int abort);
    build(w, h, rb, wb);
    nwr = 0; nrd = 0;
    @(negedge clk);
    fw = DW'(w); fh = DW'(h); rb_i = AW'(rb); wb_i = AW'(wb); start = 1;
    @(posedge clk);
    #1 start = 0; k = 0; active = 1;
    for (int n = 1; n <= mdk + 2; n++) begin
      @(posedge clk);
      #1;
      if (n == abort) begin
        active = 0;
        rst = 1;
        @(negedge clk);
        idle_chk("abort");
        chk("abort_rd_addr", rd_addr, 0);
        @(posedge clk);
        #1 rst = 0;
        break;
      end
      start = (n == poke);
      rb_i = (n == poke) ? AW'(10'h155) : AW'(rb);
      fw = (n == poke) ? DW'(8) : DW'(w);
    end
    active = 0;
  endtask
  initial begin
    int exp44 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int exp53 [8] = '{0, 1, 5, 6, 2, 3, 7, 8};
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 53 + 11) % 256);
    mem[0] = -3; mem[1] = 7; mem[4] = -128; mem[5] = 2;
    mem[2] = -5; mem[3] = -9; mem[6] = -1; mem[7] = -20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_addr", wr_addr, 0);
    rst = 0;
    run_pass(4, 4, 0, 'h100, 0, 0);
    chk("p44_nrd", nrd, 16);
    for (int i = 0; i < 16; i++) chk("p44_rd_seq", rd_got[i], exp44[i]);
    chk("p44_nwr", nwr, 4);
    chk("p44_max0", got[0], 7);
    chk("p44_max1", got[1], -1);
`ifdef POOL_PERF_EN
    chk("perf_cycles", perf_cycles, 16 + RL + 2);
`endif
    run_pass(5, 3, 0, 'h200, 0, 0);
    chk("p53_nrd", nrd, 8);
    for (int i = 0; i < 8; i++) chk("p53_rd_seq", rd_got[i], exp53[i]);
    chk("p53_nwr", nwr, 2);
    run_pass(1, 8, 0, 0, 0, 0);
    chk("p18_nrd", nrd, 0);
    chk("p18_nwr", nwr, 0);
    run_pass(4, 4, 'h3FC, 'h3FE, 3, 0);
    chk("wrap_nwr", nwr, 4);
    run_pass(4, 4, 0, 'h100, 0, 0);
    run_pass(4, 4, 0, 'h100, 18, 0);
    run_pass(6, 5, 7, 'h040, 0, 0);
    chk("p65_nwr", nwr, 6);
    run_pass(4, 4, 0, 'h100, 0, 5);
    run_pass(4, 4, 0, 'h100, 0, 0);
    chk("after_abort_nwr", nwr, 4);
    chk("after_abort_max0", got[0], 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
